frame_scaler: RTL and testbench

FRAME_SCALER -- requirements
Module: frame_scaler

---
 rtl/scale_pkg.sv | 22 ++
 rtl/axis_step_counter.sv | 51 +++++
 rtl/frame_scaler.sv | 118 +++++++++++
 tb/tb_frame_scaler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and defaults for the frame scaler.
// Optional feature macro used by frame_scaler: SCALE_MIRROR_EN.
package scale_pkg;

  typedef logic [2:0] factor_t;

  localparam factor_t FACTOR_ONE    = 3'd1;
  localparam int      SRC_W_DEFAULT = 240;
  localparam int      SRC_H_DEFAULT = 320;

  // Map a requested factor into the usable range 1..max_f.
  function automatic factor_t sanitise_factor(input factor_t req, input factor_t max_f);
    if (req == 3'd0) begin
      return FACTOR_ONE;
    end else if (req > max_f) begin
      return max_f;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/axis_step_counter.sv
// One axis of the scaler: a sub-pixel counter that advances the scaled
// coordinate once every `factor` enabled steps, saturating at all-ones.
module axis_step_counter
  import scale_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  input  logic         clear_in,
  input  factor_t      factor_in,
  output logic [W-1:0] scaled_out
);

  logic [2:0]   sub_q, sub_d;
  logic [W-1:0] scaled_q, scaled_d;

  // Next-state: clear on axis start, else step sub and bump scaled on rollover.
  always_comb begin
    sub_d    = sub_q;
    scaled_d = scaled_q;
    if (en_in) begin
      if (clear_in) begin
        sub_d    = '0;
        scaled_d = '0;
      end else if (sub_q >= factor_in - 3'd1) begin
        sub_d = '0;
        if (scaled_q != '1) begin
          scaled_d = scaled_q + W'(1);
        end
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sub_q    <= '0;
      scaled_q <= '0;
    end else begin
      sub_q    <= sub_d;
      scaled_q <= scaled_d;
    end
  end

  assign scaled_out = scaled_q;

endmodule

// File: rtl/frame_scaler.sv
// Integer up-scaler address generator: maps display (hcount, vcount) to a
// source (column, row) with a fixed two-cycle latency. Factors are latched
// only at frame start (0,0).
// Define SCALE_MIRROR_EN to mirror the source column horizontally.
module frame_scaler
  import scale_pkg::*;
#(
  parameter int SRC_W      = SRC_W_DEFAULT,
  parameter int SRC_H      = SRC_H_DEFAULT,
  parameter int H_BITS     = 11,
  parameter int V_BITS     = 10,
  parameter int MAX_FACTOR = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_BITS-1:0] hcount_in,
  input  logic [V_BITS-1:0] vcount_in,
  input  logic [2:0]        hfactor_in,
  input  logic [2:0]        vfactor_in,
  output logic [H_BITS-1:0] scaled_hcount_out,
  output logic [V_BITS-1:0] scaled_vcount_out,
  output logic              valid_addr_out,
  output logic [5:0]        factors_out
);

  localparam factor_t           MAX_F   = 3'(MAX_FACTOR);
  localparam logic [H_BITS-1:0] SRC_W_L = H_BITS'(SRC_W);
  localparam logic [V_BITS-1:0] SRC_H_L = V_BITS'(SRC_H);
`ifdef SCALE_MIRROR_EN
  localparam logic [H_BITS-1:0] SRC_W_M1 = H_BITS'(SRC_W - 1);
`endif

  logic        frame_start;
  factor_t     hf_q, hf_d, vf_q, vf_d;
  logic        live_q, live_d;
  logic [H_BITS-1:0] h_scaled;
  logic [V_BITS-1:0] v_scaled;

  logic [H_BITS-1:0] sh_q, sh_d;
  logic [V_BITS-1:0] sv_q, sv_d;
  logic              valid_q, valid_d;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // Factor latch: take the sanitised request at frame start, hold otherwise.
  // live marks that stage 1 holds a real (post-reset) input sample.
  always_comb begin
    hf_d   = hf_q;
    vf_d   = vf_q;
    live_d = 1'b1;
    if (frame_start) begin
      hf_d = sanitise_factor(hfactor_in, MAX_F);
      vf_d = sanitise_factor(vfactor_in, MAX_F);
    end
  end

  // Factor and stage-1 liveness registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hf_q   <= FACTOR_ONE;
      vf_q   <= FACTOR_ONE;
      live_q <= 1'b0;
    end else begin
      hf_q   <= hf_d;
      vf_q   <= vf_d;
      live_q <= live_d;
    end
  end

  // Stage 1: per-axis step counters (vertical steps once per line).
  axis_step_counter #(.W(H_BITS)) u_h_axis (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (1'b1),
    .clear_in  (hcount_in == '0),
    .factor_in (hf_d),
    .scaled_out(h_scaled)
  );

  axis_step_counter #(.W(V_BITS)) u_v_axis (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (hcount_in == '0),
    .clear_in  (vcount_in == '0),
    .factor_in (vf_d),
    .scaled_out(v_scaled)
  );

  // Stage 2 next-state: bounds check and optional horizontal mirror.
  always_comb begin
    valid_d = live_q && (h_scaled < SRC_W_L) && (v_scaled < SRC_H_L);
    sv_d    = v_scaled;
`ifdef SCALE_MIRROR_EN
    sh_d    = valid_d ? (SRC_W_M1 - h_scaled) : '0;
`else
    sh_d    = h_scaled;
`endif
  end

  // Stage 2 output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sh_q    <= '0;
      sv_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      sv_q    <= sv_d;
      valid_q <= valid_d;
    end
  end

  assign scaled_hcount_out = sh_q;
  assign scaled_vcount_out = sv_q;
  assign valid_addr_out    = valid_q;
  assign factors_out       = {hf_q, vf_q};

endmodule

// File: tb/tb_frame_scaler.sv
// Directed bench for frame_scaler with default parameters (240x320, max 4).
// Each cyc() call applies one input cycle; after the following call returns,
// the outputs reflect that input (two-cycle latency).
module tb_frame_scaler;

`ifdef SCALE_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [2:0]  hf, vf;
  logic [10:0] sh;
  logic [9:0]  sv;
  logic        valid;
  logic [5:0]  factors;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_scaler dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .hcount_in        (hcount),
    .vcount_in        (vcount),
    .hfactor_in       (hf),
    .vfactor_in       (vf),
    .scaled_hcount_out(sh),
    .scaled_vcount_out(sv),
    .valid_addr_out   (valid),
    .factors_out      (factors)
  );

  task automatic cyc(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    #1;
  endtask

  // Expected output column for a given source column.
  function automatic logic [10:0] exp_h(input int hs, input logic vld);
    if (!MIRROR) return 11'(hs);
    return vld ? 11'(239 - hs) : 11'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; hf = 3'd5; vf = 3'd3;
    cyc(0, 0);
    cyc(5, 3);
    for (int i = 0; i < 2; i++) begin
      cyc(7 + i, 2);
      n_vec++;
      if ({sh, sv, valid} !== 22'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got h=%0d v=%0d valid=%0b, want 0 0 0", sh, sv, valid);
      end
      n_vec++;
      if (factors !== 6'o11) begin
        n_err++;
        $display("FAIL reset_factors: got %o, want 11", factors);
      end
    end
  endtask

  task automatic test_unity_sweep();
    int   ph, pv, len;
    logic have, ev;
    hf = 3'd1; vf = 3'd1; rst = 1'b0; have = 1'b0; ph = 0; pv = 0;
    for (int v = 0; v < 750; v++) begin
      len = (v == 0 || v == 319 || v == 320 || v == 749) ? 1650 : 4;
      for (int h = 0; h < len; h++) begin
        cyc(h, v);
        n_vec++;
        if (!have) begin
          if ({sh, sv, valid} !== 22'd0) begin
            n_err++;
            $display("FAIL first_out_after_reset: got h=%0d v=%0d valid=%0b, want 0 0 0", sh, sv, valid);
          end
          n_vec++;
          if (factors !== 6'o11) begin
            n_err++;
            $display("FAIL unity_factors: got %o, want 11", factors);
          end
        end else begin
          ev = (ph < 240) && (pv < 320);
          if ({sh, sv, valid} !== {exp_h(ph, ev), 10'(pv), ev}) begin
            n_err++;
            $display("FAIL unity in=(%0d,%0d): got h=%0d v=%0d valid=%0b, want h=%0d v=%0d valid=%0b",
                     ph, pv, sh, sv, valid, exp_h(ph, ev), pv, ev);
          end
        end
        ph = h; pv = v; have = 1'b1;
      end
    end
  endtask

  task automatic test_factor3();
    int exp_tab[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    hf = 3'd3; vf = 3'd1;
    cyc(0, 0);
    n_vec++;
    if (factors !== 6'o31) begin
      n_err++;
      $display("FAIL f3_factors: got %o, want 31", factors);
    end
    for (int h = 1; h <= 9; h++) begin
      cyc(h, 0);
      n_vec++;
      if (sh !== exp_h(exp_tab[h-1], 1'b1)) begin
        n_err++;
        $display("FAIL f3_hcount in=%0d: got %0d, want %0d", h - 1, sh, exp_h(exp_tab[h-1], 1'b1));
      end
    end
  endtask

  task automatic test_boundary();
    hf = 3'd4; vf = 3'd2;
    for (int v = 0; v < 639; v++) cyc(0, v);
    n_vec++;
    if (factors !== 6'o42) begin
      n_err++;
      $display("FAIL bnd_factors: got %o, want 42", factors);
    end
    for (int h = 0; h <= 961; h++) begin
      cyc(h, 639);
      if (h == 960) begin
        n_vec++;
        if ({sh, sv, valid} !== {exp_h(239, 1'b1), 10'd319, 1'b1}) begin
          n_err++;
          $display("FAIL bnd_h959: got h=%0d v=%0d valid=%0b, want h=%0d v=319 valid=1",
                   sh, sv, valid, exp_h(239, 1'b1));
        end
      end
      if (h == 961) begin
        n_vec++;
        if ({sh, sv, valid} !== {exp_h(240, 1'b0), 10'd319, 1'b0}) begin
          n_err++;
          $display("FAIL bnd_h960: got h=%0d v=%0d valid=%0b, want h=%0d v=319 valid=0",
                   sh, sv, valid, exp_h(240, 1'b0));
        end
      end
    end
    cyc(0, 640);
    cyc(1, 640);
    n_vec++;
    if ({sh, sv, valid} !== {exp_h(0, 1'b0), 10'd320, 1'b0}) begin
      n_err++;
      $display("FAIL bnd_v640: got h=%0d v=%0d valid=%0b, want h=%0d v=320 valid=0",
               sh, sv, valid, exp_h(0, 1'b0));
    end
  endtask

  task automatic test_factor_change();
    int exp_tab[3] = '{0, 1, 1};
    hf = 3'd1; vf = 3'd1;
    for (int v = 0; v < 100; v++)
      for (int h = 0; h < 3; h++) cyc(h, v);
    hf = 3'd2;
    cyc(0, 100);
    cyc(1, 100);
    cyc(2, 100);
    n_vec++;
    if ({sh, sv} !== {exp_h(1, 1'b1), 10'd100}) begin
      n_err++;
      $display("FAIL chg_midframe_h1: got h=%0d v=%0d, want h=%0d v=100", sh, sv, exp_h(1, 1'b1));
    end
    cyc(3, 100);
    n_vec++;
    if ({sh, sv} !== {exp_h(2, 1'b1), 10'd100}) begin
      n_err++;
      $display("FAIL chg_midframe_h2: got h=%0d v=%0d, want h=%0d v=100", sh, sv, exp_h(2, 1'b1));
    end
    n_vec++;
    if (factors !== 6'o11) begin
      n_err++;
      $display("FAIL chg_factors_hold: got %o, want 11", factors);
    end
    cyc(0, 0);
    n_vec++;
    if (factors !== 6'o21) begin
      n_err++;
      $display("FAIL chg_factors_latch: got %o, want 21", factors);
    end
    cyc(1, 0);
    for (int h = 2; h <= 4; h++) begin
      cyc(h, 0);
      n_vec++;
      if (sh !== exp_h(exp_tab[h-2], 1'b1)) begin
        n_err++;
        $display("FAIL chg_hf2 in=%0d: got %0d, want %0d", h - 1, sh, exp_h(exp_tab[h-2], 1'b1));
      end
    end
  endtask

  task automatic test_sanitise();
    hf = 3'd0; vf = 3'd7;
    cyc(0, 0);
    n_vec++;
    if (factors !== 6'o14) begin
      n_err++;
      $display("FAIL san_factors_a: got %o, want 14", factors);
    end
    for (int h = 1; h <= 4; h++) cyc(h, 0);
    n_vec++;
    if (sh !== exp_h(3, 1'b1)) begin
      n_err++;
      $display("FAIL san_hf0: got %0d, want %0d", sh, exp_h(3, 1'b1));
    end
    for (int v = 1; v <= 4; v++) cyc(0, v);
    n_vec++;
    if (sv !== 10'd0) begin
      n_err++;
      $display("FAIL san_vf7_v3: got %0d, want 0", sv);
    end
    cyc(0, 5);
    n_vec++;
    if (sv !== 10'd1) begin
      n_err++;
      $display("FAIL san_vf7_v4: got %0d, want 1", sv);
    end
    hf = 3'd7; vf = 3'd0;
    cyc(0, 0);
    n_vec++;
    if (factors !== 6'o41) begin
      n_err++;
      $display("FAIL san_factors_b: got %o, want 41", factors);
    end
    for (int h = 1; h <= 4; h++) cyc(h, 0);
    n_vec++;
    if (sh !== exp_h(0, 1'b1)) begin
      n_err++;
      $display("FAIL san_hf7_h3: got %0d, want %0d", sh, exp_h(0, 1'b1));
    end
    cyc(5, 0);
    n_vec++;
    if (sh !== exp_h(1, 1'b1)) begin
      n_err++;
      $display("FAIL san_hf7_h4: got %0d, want %0d", sh, exp_h(1, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    hf = 3'd1; vf = 3'd1;
    cyc(0, 0);
    for (int h = 1; h <= 50; h++) cyc(h, 0);
    n_vec++;
    if ({sh, valid} !== {exp_h(49, 1'b1), 1'b1}) begin
      n_err++;
      $display("FAIL mid_pre_reset: got h=%0d valid=%0b, want h=%0d valid=1", sh, valid, exp_h(49, 1'b1));
    end
    hf = 3'd3; vf = 3'd3;
    cyc(0, 0);
    cyc(1, 0);
    n_vec++;
    if (factors !== 6'o33) begin
      n_err++;
      $display("FAIL mid_factors_pre: got %o, want 33", factors);
    end
    for (int h = 2; h <= 20; h++) cyc(h, 0);
    rst = 1'b1;
    cyc(21, 0);
    n_vec++;
    if ({sh, sv, valid} !== 22'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got h=%0d v=%0d valid=%0b, want 0 0 0", sh, sv, valid);
    end
    n_vec++;
    if (factors !== 6'o11) begin
      n_err++;
      $display("FAIL mid_reset_factors: got %o, want 11", factors);
    end
    rst = 1'b0;
    for (int h = 22; h <= 30; h++) cyc(h, 0);
    n_vec++;
    if (factors !== 6'o11) begin
      n_err++;
      $display("FAIL mid_factors_hold: got %o, want 11", factors);
    end
    hf = 3'd1; vf = 3'd1;
    cyc(0, 0);
    cyc(1, 0);
    n_vec++;
    if ({sh, valid} !== {exp_h(0, 1'b1), 1'b1}) begin
      n_err++;
      $display("FAIL mid_restart_h0: got h=%0d valid=%0b, want h=%0d valid=1", sh, valid, exp_h(0, 1'b1));
    end
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; hf = 3'd1; vf = 3'd1;
    test_reset();
    test_unity_sweep();
    test_factor3();
    test_boundary();
    test_factor_change();
    test_sanitise();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
